crc32_chk: RTL and testbench

Receive-side CRC-32 checker for 32-bit word streams framed by start/end markers. It is the counterpart of the transmit-side CRC-32 word generator: it recomputes the CRC over the payload words and compares it against the trailing FCS word. It reports per-frame pass/fail, length and protocol errors, and keeps saturating pass/fail counters. It sits in the receive datapath ahead of frame consumers.

---
 rtl/crc32_chk.sv | 148 ++++++++++++++
 tb/tb_crc32_chk.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/crc32_chk.sv
// Receive-side CRC-32 checker: recomputes the CRC over payload words and compares it with the trailing FCS word.
// Latency: the result strobe and its flags are registered, one cycle after the eop (or abort) word is sampled.
// Backpressure: none; every valid word is accepted, one word per clock including back-to-back frames.
module crc32_chk #(
  parameter logic [31:0] CRC_INIT  = 32'hFFFFFFFF,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [31:0] in_data,
  input  logic        clr_cnt,
  output logic        out_valid,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] frame_len,
  output logic [31:0] crc_calc,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  // Bytes are taken MSB byte first; inside a byte the LSB is shifted in first,
  // which is the same as xoring the bit-reversed byte into the register top.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_in, input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 3; i >= 0; i--) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[31] ^ data[i*8 + k];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] crc, crc_nxt, crc_stepped;
  logic [15:0] len, len_nxt;

  logic        res_vld, res_ok, res_crc_err, res_len_err;
  logic [15:0] res_len;
  logic [31:0] res_crc;

  // A sop word always restarts from the seed, so only one step is ever needed per cycle.
  assign crc_stepped = crc_step((state == FRAME && !in_sop) ? crc : CRC_INIT, in_data);

  // Frame-state decode: next CRC/length/state and the result to be registered this cycle.
  always_comb begin
    state_nxt   = state;
    crc_nxt     = crc;
    len_nxt     = len;
    res_vld     = 1'b0;
    res_ok      = 1'b0;
    res_crc_err = 1'b0;
    res_len_err = 1'b0;
    res_len     = len;
    res_crc     = crc;
    if (in_valid) begin
      if (in_sop && in_eop) begin
        // zero-payload frame; any open frame is dropped without its own result
        res_vld     = 1'b1;
        res_len_err = 1'b1;
        res_len     = 16'd0;
        res_crc     = CRC_INIT;
        state_nxt   = IDLE;
        crc_nxt     = CRC_INIT;
        len_nxt     = 16'd0;
      end else if (in_sop) begin
        // a sop inside a frame reports the aborted frame and restarts in place
        if (state == FRAME) begin
          res_vld     = 1'b1;
          res_len_err = 1'b1;
        end
        state_nxt = FRAME;
        crc_nxt   = crc_stepped;
        len_nxt   = 16'd1;
      end else if (in_eop) begin
        res_vld = 1'b1;
        if (state == IDLE) begin
          res_len_err = 1'b1;
          res_len     = 16'd0;
          res_crc     = CRC_INIT;
        end else if ({1'b0, len} > MAX_LEN) begin
          res_len_err = 1'b1;
        end else if (crc == in_data) begin
          res_ok = 1'b1;
        end else begin
          res_crc_err = 1'b1;
        end
        state_nxt = IDLE;
        crc_nxt   = CRC_INIT;
        len_nxt   = 16'd0;
      end else if (state == FRAME) begin
        crc_nxt = crc_stepped;
        len_nxt = (len == 16'hFFFF) ? len : len + 16'd1;
      end
    end
  end

  // Frame state, registered result outputs and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= CRC_INIT;
      len       <= 16'd0;
      out_valid <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      frame_len <= 16'd0;
      crc_calc  <= 32'd0;
      ok_cnt    <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      crc       <= crc_nxt;
      len       <= len_nxt;
      out_valid <= res_vld;
      crc_ok    <= res_ok;
      crc_err   <= res_crc_err;
      len_err   <= res_len_err;
      if (res_vld) begin
        frame_len <= res_len;
        crc_calc  <= res_crc;
      end
      // a clear in the same cycle as a result wins and drops that result
      if (clr_cnt) begin
        ok_cnt  <= 16'd0;
        err_cnt <= 16'd0;
      end else begin
        if (res_ok && ok_cnt != 16'hFFFF)
          ok_cnt <= ok_cnt + 16'd1;
        if ((res_crc_err || res_len_err) && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_crc32_chk.sv
// Bench for crc32_chk: directed vector table plus hand-written reset, length-limit and counter-clear sequences.
// Two instances: default limits, and MAX_WORDS=2 for the length-error boundary.
// Expected values are hand-computed constants.
module tb_crc32_chk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid_s, in_sop, in_eop, clr_cnt, clr_s;
  logic [31:0] in_data;

  logic        out_valid, crc_ok, crc_err, len_err;
  logic [15:0] frame_len, ok_cnt, err_cnt;
  logic [31:0] crc_calc;

  logic        s_out_valid, s_crc_ok, s_crc_err, s_len_err;
  logic [15:0] s_frame_len, s_ok_cnt, s_err_cnt;
  logic [31:0] s_crc_calc;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  crc32_chk u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .clr_cnt(clr_cnt), .out_valid(out_valid), .crc_ok(crc_ok),
    .crc_err(crc_err), .len_err(len_err), .frame_len(frame_len), .crc_calc(crc_calc),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  crc32_chk #(.MAX_WORDS(2)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .clr_cnt(clr_s), .out_valid(s_out_valid), .crc_ok(s_crc_ok),
    .crc_err(s_crc_err), .len_err(s_len_err), .frame_len(s_frame_len), .crc_calc(s_crc_calc),
    .ok_cnt(s_ok_cnt), .err_cnt(s_err_cnt)
  );

  typedef struct {
    logic        v, s, e;
    logic [31:0] d;
    logic        vld, ok, ce, le;
    logic [15:0] len;
    logic [31:0] crc;
    logic [15:0] okc, errc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic v, s, e, input logic [31:0] d,
                              input logic vld, ok, ce, le, input logic [15:0] len,
                              input logic [31:0] crc, input logic [15:0] okc, errc);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.d = d;
    r.vld = vld; r.ok = ok; r.ce = ce; r.le = le;
    r.len = len; r.crc = crc; r.okc = okc; r.errc = errc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, vs, s, e, input logic [31:0] d, input logic c, cs);
    @(negedge clk);
    in_valid = v; in_valid_s = vs; in_sop = s; in_eop = e; in_data = d;
    clr_cnt = c; clr_s = cs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v  s  e  data          vld ok ce le len    crc_calc       okc    errc
    tbl[0]  = mk(1, 1, 0, 32'h00000000, 0, 0, 0, 0, 16'd0, 32'h00000000, 16'd0, 16'd0);
    tbl[1]  = mk(1, 0, 1, 32'hC704DD7B, 1, 1, 0, 0, 16'd1, 32'hC704DD7B, 16'd1, 16'd0);
    tbl[2]  = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 16'd1, 32'hC704DD7B, 16'd1, 16'd0);
    tbl[3]  = mk(1, 0, 1, 32'h00000000, 1, 1, 0, 0, 16'd1, 32'h00000000, 16'd2, 16'd0);
    tbl[4]  = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 16'd1, 32'h00000000, 16'd2, 16'd0);
    tbl[5]  = mk(1, 0, 1, 32'h00000001, 1, 0, 1, 0, 16'd1, 32'h00000000, 16'd2, 16'd1);
    tbl[6]  = mk(1, 1, 0, 32'h00000000, 0, 0, 0, 0, 16'd1, 32'h00000000, 16'd2, 16'd1);
    tbl[7]  = mk(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 16'd1, 32'hC704DD7B, 16'd2, 16'd2);
    tbl[8]  = mk(1, 0, 1, 32'h00000000, 1, 1, 0, 0, 16'd1, 32'h00000000, 16'd3, 16'd2);
    tbl[9]  = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 16'd1, 32'h00000000, 16'd3, 16'd2);
    tbl[10] = mk(1, 0, 1, 32'h00000005, 1, 0, 0, 1, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd3);
    tbl[11] = mk(1, 1, 1, 32'h00000000, 1, 0, 0, 1, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd4);
    tbl[12] = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd4);
    tbl[13] = mk(1, 1, 1, 32'h12345678, 1, 0, 0, 1, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd5);
    tbl[14] = mk(1, 0, 1, 32'h00000000, 1, 0, 0, 1, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd6);
    tbl[15] = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd6);
    tbl[16] = mk(1, 0, 0, 32'h00000000, 0, 0, 0, 0, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd6);
    tbl[17] = mk(0, 0, 1, 32'h00000000, 0, 0, 0, 0, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd6);
    tbl[18] = mk(1, 0, 0, 32'h00000000, 0, 0, 0, 0, 16'd0, 32'hFFFFFFFF, 16'd3, 16'd6);
    tbl[19] = mk(1, 0, 1, 32'h00000000, 1, 1, 0, 0, 16'd3, 32'h00000000, 16'd4, 16'd6);
    tbl[20] = mk(1, 1, 0, 32'h00000000, 0, 0, 0, 0, 16'd3, 32'h00000000, 16'd4, 16'd6);
    tbl[21] = mk(1, 0, 1, 32'hC704DD7A, 1, 0, 1, 0, 16'd1, 32'hC704DD7B, 16'd4, 16'd7);

    rst_n = 1'b0;
    in_valid = 0; in_valid_s = 0; in_sop = 0; in_eop = 0; in_data = 0; clr_cnt = 0; clr_s = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_frame_len", {16'd0, frame_len}, 32'd0);
    chk("rst_crc_calc", crc_calc, 32'd0);
    chk("rst_ok_cnt", {16'd0, ok_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_small_valid", {31'd0, s_out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table against the default-limit instance
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].v, 1'b0, tbl[i].s, tbl[i].e, tbl[i].d, 1'b0, 1'b0);
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("v%0d_crc_ok", i), {31'd0, crc_ok}, {31'd0, tbl[i].ok});
        chk($sformatf("v%0d_crc_err", i), {31'd0, crc_err}, {31'd0, tbl[i].ce});
        chk($sformatf("v%0d_len_err", i), {31'd0, len_err}, {31'd0, tbl[i].le});
      end
      chk($sformatf("v%0d_frame_len", i), {16'd0, frame_len}, {16'd0, tbl[i].len});
      chk($sformatf("v%0d_crc_calc", i), crc_calc, tbl[i].crc);
      chk($sformatf("v%0d_ok_cnt", i), {16'd0, ok_cnt}, {16'd0, tbl[i].okc});
      chk($sformatf("v%0d_err_cnt", i), {16'd0, err_cnt}, {16'd0, tbl[i].errc});
    end
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    chk("strobe_one_cycle", {31'd0, out_valid}, 32'd0);

    // length limit on the MAX_WORDS=2 instance: 3 words over, 2 words at the limit
    drive(0, 1, 1, 0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 0, 0, 32'h00000000, 0, 0);
    drive(0, 1, 0, 0, 32'h00000000, 0, 0);
    drive(0, 1, 0, 1, 32'h00000000, 0, 0);
    chk("max_out_valid", {31'd0, s_out_valid}, 32'd1);
    chk("max_len_err", {31'd0, s_len_err}, 32'd1);
    chk("max_crc_ok", {31'd0, s_crc_ok}, 32'd0);
    chk("max_crc_err", {31'd0, s_crc_err}, 32'd0);
    chk("max_frame_len", {16'd0, s_frame_len}, 32'd3);
    chk("max_err_cnt", {16'd0, s_err_cnt}, 32'd1);
    drive(0, 1, 1, 0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 0, 0, 32'h00000000, 0, 0);
    drive(0, 1, 0, 1, 32'h00000000, 0, 0);
    chk("lim_crc_ok", {31'd0, s_crc_ok}, 32'd1);
    chk("lim_frame_len", {16'd0, s_frame_len}, 32'd2);
    chk("lim_ok_cnt", {16'd0, s_ok_cnt}, 32'd1);
    // clear coincides with a good result: clear wins
    drive(0, 1, 1, 0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 0, 1, 32'h00000000, 0, 1);
    chk("clr_crc_ok", {31'd0, s_crc_ok}, 32'd1);
    chk("clr_ok_cnt", {16'd0, s_ok_cnt}, 32'd0);
    chk("clr_err_cnt", {16'd0, s_err_cnt}, 32'd0);
    chk("clr_default_untouched", {16'd0, ok_cnt}, 32'd4);

    // reset mid-frame discards the frame; following non-sop words are ignored
    drive(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    drive(1, 0, 0, 0, 32'h00000000, 0, 0);
    @(negedge clk);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ok_cnt", {16'd0, ok_cnt}, 32'd0);
    chk("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 32'h00000000, 0, 0);
      chk($sformatf("post_rst_no_result%0d", i), {31'd0, out_valid}, 32'd0);
    end
    drive(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    drive(1, 0, 0, 1, 32'h00000000, 0, 0);
    chk("post_rst_crc_ok", {31'd0, crc_ok}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_frame_len", {16'd0, frame_len}, 32'd1);
    chk("post_rst_ok_cnt", {16'd0, ok_cnt}, 32'd1);
    chk("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
